// File: rtl/vector_pkg.sv
// Shared types and constants for the vector store buffer.
package vector_pkg;

    localparam int LANES      = 4;
    localparam int LANE_BYTES = 4;
    localparam int VSB_ADDR_W = 32;
    localparam int VSB_DATA_W = 32;

    typedef enum logic {
        VSB_IDLE,
        VSB_DRAIN
    } vsb_state_e;

    // Entry layout at the default widths; the FIFO mirrors it with its own parameter widths.
    typedef struct packed {
        logic [VSB_ADDR_W-1:0]                 addr;
        logic                                  sc;
        logic [LANES-1:0][VSB_DATA_W-1:0]      d;
    } vsb_entry_t;

endpackage

// File: rtl/vsb_fifo.sv
// Circular store-entry FIFO with head/tail/count; refuses pushes when full.
module vsb_fifo
    import vector_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic                          push_sc,
    input  logic [LANES-1:0][DATA_W-1:0]  push_d,
    input  logic                          pop,
    output logic [ADDR_W-1:0]             head_addr,
    output logic                          head_sc,
    output logic [LANES-1:0][DATA_W-1:0]  head_d,
    output logic [CW-1:0]                 count,
    output logic                          full,
    output logic                          empty
);

    typedef struct packed {
        logic [ADDR_W-1:0]                addr;
        logic                             sc;
        logic [LANES-1:0][DATA_W-1:0]     d;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[tail] <= '{addr: push_addr, sc: push_sc, d: push_d};
    end

    assign head_addr = mem[head].addr;
    assign head_sc   = mem[head].sc;
    assign head_d    = mem[head].d;

endmodule

// File: rtl/vector_store_buffer.sv
// Posted store buffer draining scalar/vector stores one word per beat.
// Optional feature: define VSB_OVERFLOW_FLAG_EN to add the sticky ovf output.
module vector_store_buffer
    import vector_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sc,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] wd2,
    input  logic [DATA_W-1:0] wd3,
    input  logic [DATA_W-1:0] wd4,
    output logic              full,
    output logic              empty,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef VSB_OVERFLOW_FLAG_EN
    output logic              ovf,
`endif
    input  logic              mem_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    vsb_state_e                  state, state_next;
    logic [1:0]                  lane, lane_next;
    logic                        push_ok;
    logic                        pop;
    logic                        last_lane;
    logic [ADDR_W-1:0]           head_addr;
    logic                        head_sc;
    logic [LANES-1:0][DATA_W-1:0] head_d;
    logic [CW-1:0]               count;

    assign push_ok   = wr_en && !full;
    assign last_lane = head_sc || (lane == 2'd3);
    assign pop       = (state == VSB_DRAIN) && mem_ready && last_lane;

    vsb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_addr (wr_addr),
        .push_sc   (wr_sc),
        .push_d    ({wd4, wd3, wd2, wd1}),
        .pop       (pop),
        .head_addr (head_addr),
        .head_sc   (head_sc),
        .head_d    (head_d),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= VSB_IDLE;
            lane  <= 2'd0;
        end else begin
            state <= state_next;
            lane  <= lane_next;
        end
    end

    always_comb begin
        state_next = state;
        lane_next  = lane;
        unique case (state)
            VSB_IDLE: begin
                if (push_ok) state_next = VSB_DRAIN;
            end
            VSB_DRAIN: begin
                if (mem_ready) begin
                    if (last_lane) begin
                        lane_next = 2'd0;
                        // Leaving the last entry with nothing arriving behind it.
                        if (count == CW'(1) && !push_ok) state_next = VSB_IDLE;
                    end else begin
                        lane_next = lane + 2'd1;
                    end
                end
            end
            default: state_next = VSB_IDLE;
        endcase
    end

    assign mem_we    = (state == VSB_DRAIN);
    assign mem_addr  = mem_we ? head_addr + ADDR_W'(lane) * ADDR_W'(LANE_BYTES) : '0;
    assign mem_wdata = mem_we ? head_d[lane] : '0;

`ifdef VSB_OVERFLOW_FLAG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              ovf <= 1'b0;
        else if (wr_en && full) ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_vector_store_buffer.sv
// Self-checking bench: word-level queue model plus directed and random stimulus.
module tb_vector_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sc = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wd1 = '0, wd2 = '0, wd3 = '0, wd4 = '0;
    logic        mem_ready = 1'b0;
    logic        full, empty, mem_we;
    logic [31:0] mem_addr, mem_wdata;
`ifdef VSB_OVERFLOW_FLAG_EN
    logic        ovf;
`endif

    vector_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sc     (wr_sc),
        .wr_addr   (wr_addr),
        .wd1       (wd1),
        .wd2       (wd2),
        .wd3       (wd3),
        .wd4       (wd4),
        .full      (full),
        .empty     (empty),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef VSB_OVERFLOW_FLAG_EN
        .ovf       (ovf),
`endif
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: pending words in drain order, and per-entry remaining word counts.
    logic [63:0] wq[$];
    int          eq[$];
    bit          ovf_m = 1'b0;
    int          dut_beats;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("empty", empty, eq.size() == 0);
        chk("full", full, eq.size() == DEPTH);
        chk("mem_we", mem_we, eq.size() != 0);
        if (wq.size() != 0) begin
            chk("mem_addr", mem_addr, wq[0][63:32]);
            chk("mem_wdata", mem_wdata, wq[0][31:0]);
        end else begin
            chk("mem_addr_idle", mem_addr, 0);
            chk("mem_wdata_idle", mem_wdata, 0);
        end
`ifdef VSB_OVERFLOW_FLAG_EN
        chk("ovf", ovf, ovf_m);
`endif
    endtask

    task automatic clear_model();
        wq.delete();
        eq.delete();
        ovf_m = 1'b0;
    endtask

    // Drive one cycle's inputs (called just after a falling edge), advance model, check.
    task automatic step(input bit en, input bit sc, input logic [31:0] a,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] d3, input logic [31:0] d4, input bit rdy);
        bit          full_pre;
        logic [31:0] d[4];
        logic [31:0] la;
        wr_en = en; wr_sc = sc; wr_addr = a;
        wd1 = d1; wd2 = d2; wd3 = d3; wd4 = d4; mem_ready = rdy;
        d[0] = d1; d[1] = d2; d[2] = d3; d[3] = d4;
        full_pre = (eq.size() == DEPTH);
        if (mem_we && rdy) dut_beats++;
        if (eq.size() != 0 && rdy) begin
            void'(wq.pop_front());
            eq[0] = eq[0] - 1;
            if (eq[0] == 0) void'(eq.pop_front());
        end
        if (en) begin
            if (full_pre) begin
                ovf_m = 1'b1;
            end else begin
                for (int l = 0; l < (sc ? 1 : 4); l++) begin
                    la = a + 32'(4 * l);
                    wq.push_back({la, d[l]});
                end
                eq.push_back(sc ? 1 : 4);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        // Reset held with wr_en asserted: nothing may be captured.
        rst = 1'b0; wr_en = 1'b1; wr_sc = 1'b1; wr_addr = 32'h40; wd1 = 32'hDEAD; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
        end
        clear_model();
        wr_en = 1'b0;
        rst = 1'b1;
        idle(1'b1);

        // Scalar store.
        step(1'b1, 1'b1, 32'h100, 32'hF, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("sc_we", mem_we, 1);
        chk("sc_addr", mem_addr, 32'h100);
        chk("sc_data", mem_wdata, 32'hF);
        idle(1'b1);
        chk("sc_empty", empty, 1);

        // Vector store on consecutive cycles.
        step(1'b1, 1'b0, 32'h200, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
        chk("v0_addr", mem_addr, 32'h200); chk("v0_data", mem_wdata, 32'd1);
        idle(1'b1);
        chk("v1_addr", mem_addr, 32'h204); chk("v1_data", mem_wdata, 32'd2);
        idle(1'b1);
        chk("v2_addr", mem_addr, 32'h208); chk("v2_data", mem_wdata, 32'd3);
        idle(1'b1);
        chk("v3_addr", mem_addr, 32'h20C); chk("v3_data", mem_wdata, 32'd4);
        idle(1'b1);
        chk("v_empty", empty, 1);

        // Stall on lane 2.
        step(1'b1, 1'b0, 32'h200, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
        idle(1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("stall_addr", mem_addr, 32'h204);
            chk("stall_data", mem_wdata, 32'd2);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("stall_empty", empty, 1);

        // Fill while memory is blocked, overflow, then drain 16 beats.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 32'h1000 * (i + 1), 32'h10 * i + 1, 32'h10 * i + 2,
                 32'h10 * i + 3, 32'h10 * i + 4, 1'b0);
        chk("fill_full", full, 1);
        step(1'b1, 1'b1, 32'h9000, 32'hBAD, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("drop_full", full, 1);
`ifdef VSB_OVERFLOW_FLAG_EN
        chk("drop_ovf", ovf, 1);
`endif
        dut_beats = 0;
        for (int i = 0; i < 16; i++) idle(1'b1);
        chk("drain_beats", dut_beats, 16);
        chk("drain_empty", empty, 1);

        // Wrap-around with scalars interleaved with drains.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'(i + 100), 32'h0, 32'h0, 32'h0, 1'b0);
            step(1'b1, 1'b1, 32'h400 + 32'(4 * i), 32'(i + 200), 32'h0, 32'h0, 32'h0, 1'b1);
        end
        for (int i = 0; i < 16; i++) idle(1'b1);
        chk("wrap_empty", empty, 1);

        // Address wrap at the top of the space.
        step(1'b1, 1'b0, 32'hFFFF_FFF8, 32'hA, 32'hB, 32'hC, 32'hD, 1'b1);
        idle(1'b1); idle(1'b1);
        chk("awrap_addr", mem_addr, 32'h0);

        // Asynchronous reset in the middle of a drain.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        clear_model();
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(1'b1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4) : $urandom;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a,
                 $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 24; i++) idle(1'b1);
        chk("final_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_store_buffer.md
# vector_store_buffer

Posted store buffer between `vector_cpu` and single-port word-wide data memory. Captures each CPU store (scalar or 4-lane vector) in one cycle and drains it to memory one 32-bit word per accepted beat. The core never waits on memory until the buffer is full. Drain is in order; each vector drains lane 1 first through lane 4 last.

## Interface
Parameters:
- `DEPTH`, 4: store entries held; power of two, ≥2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: lane data width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: store request from core (`mem_wr_enable`).
- `wr_sc`  in  1: 1 = scalar store (lane 1 only), 0 = vector store (4 lanes).
- `wr_addr`  in  ADDR_W: byte address of lane 1.
- `wd1`..`wd4`  in  DATA_W each: lane data.
- `full`  out  1: buffer cannot accept; core must stall.
- `empty`  out  1: no entries pending.
- `mem_we`  out  1: word write valid.
- `mem_addr`  out  ADDR_W: word write byte address.
- `mem_wdata`  out  DATA_W: word write data.
- `mem_ready`  in  1: memory accepts the current word this cycle.

## Operation
- Entry fields: `addr`, `sc`, `d[4]`. Storage is a circular FIFO with `head`, `tail` (log2 DEPTH bits, wrap modulo DEPTH) and `count` (0..DEPTH).
- Push: `wr_en && !full` at an edge writes the entry at `tail`, then `tail++` and `count++`.
- `wr_en && full`: request dropped, FIFO unchanged. The core is required to honour `full`.
- FSM states:
  - IDLE: `count==0`. Moves to DRAIN on the edge after a push.
  - DRAIN: head entry is presented, with lane counter `lane` (2 bits).
- In DRAIN, `mem_we`=1, `mem_addr = head.addr + 4*lane` (wraps modulo 2^ADDR_W), `mem_wdata = head.d[lane]`.
- Beat accepted when `mem_we && mem_ready`:
  - If `head.sc` or `lane==3`: pop (`head++`, `count--`, `lane`←0). Go to IDLE if the FIFO becomes empty, otherwise stay in DRAIN.
  - Otherwise: `lane++`.
- If `mem_ready`=0, all `mem_*` outputs hold stable. This is required.
- Push and pop in the same cycle: both take effect and `count` is unchanged. When `count==DEPTH`, `full` is asserted and the push is refused even if a pop completes that cycle. `full` is a registered-state function only, with no combinational path from `mem_ready`.
- `full = (count==DEPTH)`, `empty = (count==0)`. Both are purely from registers.

## Timing
- Reset (asynchronous, `rst`=0): `count`=0, `head`=`tail`=0, `lane`=0, state IDLE. Outputs: `full`=0, `empty`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Entry storage is not reset.
- Reset asserted mid-drain aborts the current entry immediately. Pending stores are discarded.
- Latency, empty buffer, `mem_ready` held 1:
  - Push at edge k → `mem_we` high in cycle k+1.
  - Scalar store: one beat, `empty` high after edge k+1.
  - Vector store: beats in cycles k+1..k+4, `empty` high after edge k+4.
- Sustained throughput is one word per cycle. With `mem_ready` tied high, a vector store occupies the drain for 4 cycles.
- `full` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the first pop from full.

## Configuration
- `VSB_OVERFLOW_FLAG_EN` defined:
  - Adds output `ovf` (1 bit), reset 0.
  - `ovf` is set sticky on any edge with `wr_en && full`.
  - `ovf` is cleared only by reset.
- Not defined: port absent, dropped requests are silent. All other behaviour is identical.

## Structure
- Package `vector_pkg`:
  - `LANES`=4.
  - `vsb_entry_t` struct (`addr`, `sc`, `d[LANES]`).
  - `vsb_state_e` enum (`VSB_IDLE`, `VSB_DRAIN`).
  - Lane byte stride constant `LANE_BYTES`=4.
- Natural sub-module: `vsb_fifo`, the parameterised circular storage with head/tail/count and full/empty.
- The top holds the FSM, lane counter and memory-side mux.

## Test plan
- Reset with `wr_en`=1 held → `empty`=1, `full`=0, `mem_we`=0 until `rst` is released. No push occurs while `rst`=0.
- Scalar store, `wr_addr`=0x100, `wd1`=0xF, `mem_ready`=1 → exactly one beat (0x100, 0xF) in the cycle after the push, then `empty`=1.
- Vector store, `wr_addr`=0x200, `wd`=1,2,3,4 → beats (0x200,1), (0x204,2), (0x208,3), (0x20C,4) on consecutive cycles.
- `mem_ready`=0 for 3 cycles during lane 2 of a vector → `mem_addr`=0x204 and `mem_wdata`=2 stable throughout, then the drain resumes in order.
- `mem_ready`=0, push 4 vectors → `full`=1 after the 4th push, a 5th `wr_en` is dropped (`ovf`=1 when enabled), and releasing `mem_ready` drains exactly 16 beats in push order.
- Wrap-around: 6 scalar stores interleaved with drains → `head`/`tail` wrap past DEPTH, and the data order matches the push order.
